// File: rtl/sound_cmd_pkg.sv
// Shared types, status-register bit positions and width helper for the
// main-to-sound command mailbox.
package sound_cmd_pkg;

  typedef enum logic {
    IRQ_LEVEL  = 1'b0,
    IRQ_LEGACY = 1'b1
  } irq_mode_e;

  localparam int ST_OVF   = 7;
  localparam int ST_FULL  = 6;
  localparam int ST_EMPTY = 5;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sound_cmd_fifo_core.sv
// DEPTH x DW command FIFO; a push into a full FIFO still lands when a pop
// retires the head in the same cycle.
module sound_cmd_fifo_core
  import sound_cmd_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push_i,
  input  logic                      pop_i,
  input  logic [DW-1:0]             din_i,
  output logic [cnt_w(DEPTH)-1:0]   count_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic                      drop_o,
  output logic                      next_empty_o,
  output logic [DW-1:0]             head_nxt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full_q, empty_q;
  logic          push_do, pop_do;

  always_comb begin
    pop_do  = pop_i & ~empty_q;
    push_do = push_i & (~full_q | pop_do);
    wp_d    = wp_q + AW'(push_do);
    rp_d    = rp_q + AW'(pop_do);
    cnt_d   = cnt_q + CW'(push_do) - CW'(pop_do);
  end

  assign drop_o       = push_i & ~push_do;
  assign next_empty_o = (cnt_d == '0);
  // The new head may be the word being written this very cycle.
  assign head_nxt_o   = (push_do && (rp_d == wp_q)) ? din_i : mem_q[rp_d];

  assign count_o = cnt_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == CW'(DEPTH));
      empty_q <= (cnt_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_do) mem_q[wp_q] <= din_i;
  end

endmodule

// File: rtl/sound_cmd_mailbox.sv
// Main-to-sound command mailbox: strobe edge detection, IRQ, dout register.
// Define SOUND_CMD_STATUS_EN to add the addr=1 status register / overflow clear.
module sound_cmd_mailbox
  import sound_cmd_pkg::*;
#(
  parameter int            DW        = 8,
  parameter int            DEPTH     = 4,
  parameter int            IRQ_MODE  = 0,
  parameter logic [DW-1:0] EMPTY_VAL = 8'hFF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_n,
  input  logic [DW-1:0]           din,
  input  logic                    rd_cs_n,
  input  logic                    rd_n,
  input  logic                    addr,
  output logic [DW-1:0]           dout,
  output logic                    irq_n,
  output logic [cnt_w(DEPTH)-1:0] count,
  output logic                    full,
  output logic                    empty,
  output logic                    overflow
);

  localparam bit LEGACY = (IRQ_MODE == int'(IRQ_LEGACY));

  logic          wr_n_q, acc_q, acc;
  logic          push_ev, acc_fall, pop_ev, st_clr, st_start;
  logic          stat_q, stat_d;
  logic          ovf_q, ovf_d, flag_q, flag_d, irq_n_q, irq_n_d;
  logic          drop, next_empty;
  logic [DW-1:0] head_nxt, dout_q, dout_d;
  logic [7:0]    status_w;

  assign acc      = ~rd_cs_n & ~rd_n;
  assign push_ev  = wr_n & ~wr_n_q;
  assign acc_fall = acc_q & ~acc;

  always_comb begin
    status_w           = '0;
    status_w[ST_OVF]   = ovf_q;
    status_w[ST_FULL]  = full;
    status_w[ST_EMPTY] = empty;
    status_w[3:0]      = 4'(count);
  end

`ifdef SOUND_CMD_STATUS_EN
  assign pop_ev   = acc_fall & ~addr;
  assign st_clr   = acc_fall & addr;
  assign st_start = acc & ~acc_q & addr;
`else
  assign pop_ev   = acc_fall;
  assign st_clr   = 1'b0;
  assign st_start = 1'b0;
  logic unused_status;
  assign unused_status = ^{addr, status_w};
`endif

  sound_cmd_fifo_core #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push_ev),
    .pop_i        (pop_ev),
    .din_i        (din),
    .count_o      (count),
    .full_o       (full),
    .empty_o      (empty),
    .drop_o       (drop),
    .next_empty_o (next_empty),
    .head_nxt_o   (head_nxt)
  );

  always_comb begin
    dout_d = dout_q;
    // A status snapshot is frozen for the whole status access.
    if (st_start)                dout_d = DW'(status_w);
    else if (stat_q && acc)      dout_d = dout_q;
    else if (!next_empty)        dout_d = head_nxt;
    stat_d  = st_start | (acc & stat_q);
    ovf_d   = (ovf_q & ~st_clr) | drop;
    flag_d  = acc ? 1'b0 : (push_ev ? 1'b1 : flag_q);
    irq_n_d = LEGACY ? ~flag_d : next_empty;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_n_q  <= wr_n;
      acc_q   <= acc;
      stat_q  <= 1'b0;
      ovf_q   <= 1'b0;
      flag_q  <= 1'b0;
      irq_n_q <= 1'b1;
      dout_q  <= EMPTY_VAL;
    end else begin
      wr_n_q  <= wr_n;
      acc_q   <= acc;
      stat_q  <= stat_d;
      ovf_q   <= ovf_d;
      flag_q  <= flag_d;
      irq_n_q <= irq_n_d;
      dout_q  <= dout_d;
    end
  end

  assign dout     = dout_q;
  assign irq_n    = irq_n_q;
  assign overflow = ovf_q;

endmodule

// File: doc/sound_cmd_mailbox.md
Name: sound_cmd_mailbox

Overview:
- Parametrised successor to the single-byte main-to-sound command latch and its IRQ flip-flop.
- Buffers up to DEPTH commands from the main CPU in a FIFO, so back-to-back sound codes are not lost.
- Presents the head entry to the sound CPU read mux and drives the sound CPU interrupt line.
- Sits between the main CPU write decode and the sound CPU address decoder; everything runs in the clk domain, with both CPU strobes treated as level inputs.

Parameters:
- DW, 8: command data width.
- DEPTH, 4: FIFO entries; must be a power of two, at least 2.
- IRQ_MODE, 0: 0 = level mode, IRQ asserted while the FIFO is non-empty. 1 = legacy mode, IRQ set on push and cleared on any sound-CPU read access.
- EMPTY_VAL, 8'hFF: value on dout after reset, before the first push.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- wr_n  in  1  main CPU latch strobe, active low; push happens on its rising edge.
- din  in  DW  main CPU data bus.
- rd_cs_n  in  1  sound CPU latch select, active low.
- rd_n  in  1  sound CPU read strobe (E and R/W), active low.
- addr  in  1  register select: 0 = data, 1 = status. Used only with the optional feature.
- dout  out  DW  data to the sound CPU read mux, registered.
- irq_n  out  1  sound CPU IRQ, active low, registered.
- count  out  $clog2(DEPTH)+1  current occupancy.
- full  out  1  occupancy equals DEPTH.
- empty  out  1  occupancy is zero.
- overflow  out  1  sticky: a push was dropped.

Behaviour:
- Reset: synchronous. After the first clk edge with rst=1:
  - pointers = 0, count = 0, empty = 1, full = 0, overflow = 0
  - irq_n = 1
  - dout = EMPTY_VAL
  - edge-detect registers load the current strobe levels, so no false edge is seen after reset.
- Push:
  - push_ev = rising edge of wr_n, detected against a 1-cycle delayed copy; one clk pulse.
  - din is sampled in the same cycle as push_ev.
- Read access:
  - acc = ~rd_cs_n & ~rd_n.
  - pop_ev = falling edge of acc (end of the access), when addr = 0.
  - Each access pops at most once, regardless of how long acc is held.
- Not full, no pop: push writes mem[wp], wp++, count++.
- Full, no simultaneous pop: push is dropped, overflow <= 1, contents unchanged.
- Pop when not empty: rp++, count--. Pop when empty: ignored, no state change.
- Simultaneous push_ev and pop_ev:
  - Non-empty: both are performed; count is unchanged, including when full (no overflow in that case).
  - Empty: push performed, pop ignored.
- Pointers wrap modulo DEPTH.
- dout:
  - Each cycle, dout <= mem[rp] if the post-update FIFO is non-empty; otherwise dout holds its last value.
  - Latency: a push into an empty FIFO is visible on dout 1 clk after push_ev.
  - dout is stable throughout an access, because the pop takes effect only at the end of the access.
- IRQ, IRQ_MODE = 0: irq_n <= next_empty, i.e. deasserts the cycle after the pop that empties the FIFO.
- IRQ, IRQ_MODE = 1:
  - Flag set on push_ev, cleared while acc = 1 (either address).
  - Clear has priority over set in the same cycle.
  - irq_n = ~flag.
- full, empty, count: registered, and consistent with each other in every cycle.

Optional Feature:
- Macro: SOUND_CMD_STATUS_EN.
- Defined:
  - With addr = 1, dout shows status {overflow, full, empty, 1'b0, count zero-extended to 4 bits}, registered and sampled at the start of acc.
  - The falling edge of acc with addr = 1 clears overflow and does not pop.
  - With addr = 0, behaviour is as in Behaviour.
- Undefined: addr is ignored and every access is a data access; overflow clears only on reset.

Decomposition:
- Package sound_cmd_pkg:
  - irq_mode_e with IRQ_LEVEL = 0 and IRQ_LEGACY = 1.
  - Status bit index constants (ST_OVF = 7, ST_FULL = 6, ST_EMPTY = 5).
  - Function cnt_w(depth).
- Sub-module sound_cmd_fifo_core:
  - Synchronous DEPTH x DW FIFO with push, pop, count, full and empty.
  - Implements the simultaneous-event rules above.
  - The top level holds edge detection, the IRQ logic, the dout register and the status logic.

Test Plan:
- Reset, then push 8'h8A via a wr_n low-then-high pulse -> 1 clk later dout = 8'h8A, count = 1, irq_n = 0. Read access with addr = 0 -> after acc falls, empty = 1 and irq_n = 1 (level mode).
- Push 8'h01, 8'h0F, 8'h09, 8'h8A with DEPTH = 4, then a fifth push 8'hFD -> full = 1, overflow = 1, and four reads return 01, 0F, 09, 8A in order.
- FIFO full, push and pop coincide on the same clk -> count stays at 4, overflow stays 0, and the oldest entry is replaced at the tail.
- Read access with the FIFO empty -> dout holds its last value, count = 0, and pointers are unchanged.
- IRQ_MODE = 1, push 8'h10 while acc = 1 on the same cycle -> irq_n stays 1; a later push with no access -> irq_n = 0.
- SOUND_CMD_STATUS_EN, after an overflow, status read -> dout = 8'b1100_0100. After the access ends -> overflow = 0 and count is still 4.
